mips_main_ctrl_fsm: RTL and testbench
=====================================

Name: mips_main_ctrl_fsm

Overview:
- Multicycle MIPS main control unit. Sits directly upstream of the ALU-control decoder and the datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and muxes.
- Supplies the decoder with alu_op plus sanitised opcode/funct fields, so I-type immediates can never alias an R-type funct code.

Parameters:
MEM_WAIT_CYCLES, 0, extra stall cycles held in FETCH and MEMRD before memory data is valid (0..15).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
instr_opcode  input  6  IR[31:26]
instr_funct  input  6  IR[5:0]
alu_zero  input  1  ALU zero flag, valid in BRANCH state
pc_en  output  1  PC register enable (unconditional or taken branch)
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_wr  output  1  memory write strobe
ir_wr  output  1  IR/MDR capture enable
reg_dst  output  1  write register: 0=rt, 1=rd
mem_to_reg  output  1  writeback data: 0=ALUOut, 1=MDR
reg_wr  output  1  register file write enable
alu_src_a  output  1  ALU A input: 0=PC, 1=rs
alu_src_b  output  2  ALU B input: 00=rt, 01=const 4, 10=sign/zero-ext imm, 11=imm<<2
alu_op  output  2  00=add, 01=sub, 10=decode
alu_opcode  output  6  opcode forwarded to the decoder
alu_funct  output  6  instr_funct for R-type; 6'b111111 otherwise
pc_src  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
zero_ext  output  1  zero-extend immediate (andi/ori/xori)
illegal_op  output  1  one-cycle pulse on unknown opcode
state  output  4  current state, for debug

Behaviour:
- Reset: state=FETCH, wait counter=0.
  - FETCH outputs apply from the first cycle after reset.
  - illegal_op=0, and no write strobes are asserted.
  - rst mid-instruction aborts it; no partial reg_wr or mem_wr occurs after the reset edge.
- All outputs are a combinational Moore decode of state. Exceptions: pc_en uses alu_zero; alu_funct and zero_ext use the IR fields.
- IR is stable from DECODE onward.
- Unlisted outputs are 0 in each state.
- States:
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
    - Holds MEM_WAIT_CYCLES extra cycles.
    - ir_wr=1 and pc_en=1 only on the final cycle, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next state by opcode:
    - 000000 -> RTYPE_EX
    - lw 100011 / sw 101011 -> MEMADR
    - beq 000100 -> BRANCH
    - j 000010 -> JUMP
    - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> IMM_EX
    - anything else -> FETCH, with illegal_op=1 for that DECODE cycle.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1. Holds MEM_WAIT_CYCLES extra cycles, then -> MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_wr=1 -> FETCH.
  - MEMWR: iord=1, mem_wr=1 for exactly 1 cycle -> FETCH.
  - RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_wr=1 -> FETCH.
  - IMM_EX: alu_src_a=1, alu_src_b=10, alu_op=10 -> IMMWB.
  - IMMWB: reg_dst=0, mem_to_reg=0, reg_wr=1 -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=alu_zero -> FETCH.
  - JUMP: pc_src=10, pc_en=1 -> FETCH.
- Wait counter:
  - 4-bit, cleared on entry to FETCH/MEMRD.
  - Advances while count < MEM_WAIT_CYCLES; the state exits when count == MEM_WAIT_CYCLES.
  - No wrap is possible.
- zero_ext = 1 iff instr_opcode is andi, ori or xori.
- Cycle counts, for MEM_WAIT_CYCLES=0 (each FETCH/MEMRD adds MEM_WAIT_CYCLES):
  - lw=5
  - sw, R-type, I-type=4
  - beq, j=3

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) decodes DECODE -> BRANCH, and BRANCH uses pc_en = ~alu_zero for bne.
- Undefined: bne is illegal (illegal_op pulse, return to FETCH, no state change in datapath).

Decomposition:
- Shared package/defines file holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, ALUWB=7, IMM_EX=8, IMMWB=9, BRANCH=10, JUMP=11
  - opcode constants, alongside the existing OP* defines
  - alu_op codes
  - ALU_FUNCT_NONE = 6'b111111
- Sub-module: mem_wait_counter (parameterised stall counter with clear/done), instantiated once and shared by FETCH and MEMRD.

Test Plan:
- Reset, then rst held 3 cycles mid-MEMRD -> state=0, reg_wr=0 and mem_wr=0 throughout, FETCH resumes on release.
- lw (opcode 100011), MEM_WAIT_CYCLES=0 -> states 0,1,2,3,4 then 0; reg_wr=1 and mem_to_reg=1 only in cycle 5; ir_wr=1 only in cycle 1.
- ori with imm[5:0]=100100 -> alu_op=10, alu_funct=111111, zero_ext=1, reg_dst=0 in IMMWB.
- beq with alu_zero=1 -> pc_en=1, pc_src=01 in BRANCH; with alu_zero=0 -> pc_en=0.
- opcode 111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, no write strobes.
- MEM_WAIT_CYCLES=2 with sw -> FETCH lasts 3 cycles (ir_wr on 3rd only), mem_wr asserted exactly 1 cycle, total 6 cycles.

Source files
------------

// File: rtl/mips_main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM:
// state encodings, opcode constants, ALU op codes and the control word.
// Optional feature macro: MIPS_CTRL_BNE_EN (adds bne decode).
package mips_main_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALUWB    = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMMWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_DECODE = 2'b10;

  // Funct value that no R-type instruction uses; keeps immediates from aliasing.
  localparam logic [5:0] ALU_FUNCT_NONE = 6'b111111;

  // Moore control word produced by the state decode.
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_main_ctrl_fsm_if.sv
// Control bus between the main control FSM (master) and the datapath /
// ALU-control decoder (slave).
interface mips_main_ctrl_fsm_if;
  logic [5:0] instr_opcode;
  logic [5:0] instr_funct;
  logic       alu_zero;
  logic       pc_en;
  logic       iord;
  logic       mem_wr;
  logic       ir_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_wr;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [5:0] alu_opcode;
  logic [5:0] alu_funct;
  logic [1:0] pc_src;
  logic       zero_ext;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  instr_opcode, instr_funct, alu_zero,
    output pc_en, iord, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
           alu_src_a, alu_src_b, alu_op, alu_opcode, alu_funct, pc_src,
           zero_ext, illegal_op, state
  );

  modport slave (
    output instr_opcode, instr_funct, alu_zero,
    input  pc_en, iord, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
           alu_src_a, alu_src_b, alu_op, alu_opcode, alu_funct, pc_src,
           zero_ext, illegal_op, state
  );
endinterface

// File: rtl/mips_main_ctrl_fsm_mem_wait_counter.sv
// Memory stall counter shared by FETCH and MEMRD. Saturates at MAX_WAIT,
// done is high once MAX_WAIT extra cycles have elapsed since clear.
module mem_wait_counter #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam logic [3:0] MAX = 4'(MAX_WAIT);

  logic [3:0] count;

  // Count up while enabled; saturating compare means the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr)           count <= 4'd0;
    else if (en && count < MAX) count <= count + 4'd1;
  end

  assign done = (count == MAX);
endmodule

// File: rtl/mips_main_ctrl_fsm.sv
// Multicycle MIPS main control unit: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables and muxes.
// Optional feature macro: MIPS_CTRL_BNE_EN (bne branches on ~alu_zero).
module mips_main_ctrl_fsm
  import mips_main_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_main_ctrl_fsm_if.master bus
);
  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   wait_done, wait_en, wait_clr;

  // Counter runs only in the two memory-wait states; any transition clears
  // it, so each FETCH/MEMRD visit starts from zero.
  assign wait_en  = (state_q == S_FETCH) || (state_q == S_MEMRD);
  assign wait_clr = (state_d != state_q);

  mem_wait_counter #(.MAX_WAIT(MEM_WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (wait_clr),
    .en   (wait_en),
    .done (wait_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore control decode.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        if (wait_done) begin
          ctrl.ir_wr = 1'b1;
          ctrl.pc_en = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
        case (bus.instr_opcode)
          OP_RTYPE:                          state_d = S_RTYPE_EX;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ:                            state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:                            state_d = S_BRANCH;
`endif
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI:                   state_d = S_IMM_EX;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (bus.instr_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
        if (wait_done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_wr = 1'b1;
        state_d     = S_FETCH;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALU_DECODE;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_wr  = 1'b1;
        state_d      = S_FETCH;
      end
      S_IMM_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_DECODE;
        state_d        = S_IMMWB;
      end
      S_IMMWB: begin
        ctrl.reg_wr = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
        ctrl.pc_en     = (bus.instr_opcode == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
`else
        ctrl.pc_en     = bus.alu_zero;
`endif
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src = 2'b10;
        ctrl.pc_en  = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked while rst is high so nothing commits on the reset edge.
  assign bus.pc_en      = ctrl.pc_en  & ~rst;
  assign bus.ir_wr      = ctrl.ir_wr  & ~rst;
  assign bus.mem_wr     = ctrl.mem_wr & ~rst;
  assign bus.reg_wr     = ctrl.reg_wr & ~rst;
  assign bus.illegal_op = ctrl.illegal_op & ~rst;
  assign bus.iord       = ctrl.iord;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.state      = state_q;

  // Decoder feed: only R-type forwards its funct, immediates get a safe code.
  assign bus.alu_opcode = bus.instr_opcode;
  assign bus.alu_funct  = (bus.instr_opcode == OP_RTYPE) ? bus.instr_funct : ALU_FUNCT_NONE;
  assign bus.zero_ext   = is_zext(bus.instr_opcode);
endmodule

// File: tb/tb_mips_main_ctrl_fsm.sv
// Directed bench for mips_main_ctrl_fsm: one DUT with no memory wait,
// one with MEM_WAIT_CYCLES=2.
module tb_mips_main_ctrl_fsm;
  import mips_main_ctrl_fsm_pkg::*;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst2 = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_main_ctrl_fsm_if bus0 ();
  mips_main_ctrl_fsm_if bus2 ();

  mips_main_ctrl_fsm #(.MEM_WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
  mips_main_ctrl_fsm #(.MEM_WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst2), .bus(bus2));

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves DUT0 in its first FETCH cycle with rst released.
  task automatic reset0();
    rst0 = 1'b1; step(); rst0 = 1'b0; #1;
  endtask

  task automatic test_reset();
    bus0.instr_opcode = OP_LW; bus0.instr_funct = 6'd0; bus0.alu_zero = 1'b0;
    rst0 = 1'b1; step(); step();
    n_chk++; if (bus0.state !== 4'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus0.state); end
    n_chk++; if (bus0.illegal_op !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %b want 0", bus0.illegal_op); end
    n_chk++; if ({bus0.reg_wr, bus0.mem_wr, bus0.ir_wr, bus0.pc_en} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_strobes: got %b want 0000", {bus0.reg_wr, bus0.mem_wr, bus0.ir_wr, bus0.pc_en}); end
    rst0 = 1'b0; #1;
    n_chk++; if (bus0.ir_wr !== 1'b1) begin n_fail++; $display("FAIL rst_first_fetch_ir_wr: got %b want 1", bus0.ir_wr); end
    step(); step(); step();
    n_chk++; if (bus0.state !== 4'd3) begin n_fail++; $display("FAIL rst_reach_memrd: got %0d want 3", bus0.state); end
    rst0 = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (bus0.state !== 4'd0) begin n_fail++; $display("FAIL rst_mid_state[%0d]: got %0d want 0", i, bus0.state); end
      n_chk++; if ({bus0.reg_wr, bus0.mem_wr} !== 2'b00) begin n_fail++;
        $display("FAIL rst_mid_wr[%0d]: got %b want 00", i, {bus0.reg_wr, bus0.mem_wr}); end
    end
    rst0 = 1'b0; #1;
    n_chk++; if (bus0.state !== 4'd0 || bus0.ir_wr !== 1'b1) begin n_fail++;
      $display("FAIL rst_resume: got state %0d ir_wr %b want 0/1", bus0.state, bus0.ir_wr); end
    step();
    n_chk++; if (bus0.state !== 4'd1) begin n_fail++; $display("FAIL rst_resume_decode: got %0d want 1", bus0.state); end
  endtask

  task automatic test_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    logic exp_rw[6] = '{0, 0, 0, 0, 1, 0};
    logic exp_ir[6] = '{1, 0, 0, 0, 0, 1};
    bus0.instr_opcode = OP_LW; bus0.instr_funct = 6'd0;
    reset0();
    for (int c = 0; c < 6; c++) begin
      n_chk++; if (bus0.state !== 4'(exp_st[c])) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", c, bus0.state, exp_st[c]); end
      n_chk++; if (bus0.reg_wr !== exp_rw[c] || bus0.mem_to_reg !== exp_rw[c]) begin n_fail++;
        $display("FAIL lw_wb[%0d]: got reg_wr %b mem_to_reg %b want %b", c, bus0.reg_wr, bus0.mem_to_reg, exp_rw[c]); end
      n_chk++; if (bus0.ir_wr !== exp_ir[c]) begin n_fail++; $display("FAIL lw_ir_wr[%0d]: got %b want %b", c, bus0.ir_wr, exp_ir[c]); end
      if (c == 3) begin
        n_chk++; if (bus0.iord !== 1'b1) begin n_fail++; $display("FAIL lw_iord: got %b want 1", bus0.iord); end
      end
      step();
    end
  endtask

  task automatic test_ori();
    bus0.instr_opcode = OP_ORI; bus0.instr_funct = 6'b100100;
    reset0(); step();
    n_chk++; if (bus0.state !== 4'd1 || bus0.alu_src_b !== 2'b11) begin n_fail++;
      $display("FAIL ori_decode: got state %0d src_b %b want 1/11", bus0.state, bus0.alu_src_b); end
    step();
    n_chk++; if (bus0.state !== 4'd8) begin n_fail++; $display("FAIL ori_ex_state: got %0d want 8", bus0.state); end
    n_chk++; if (bus0.alu_op !== 2'b10) begin n_fail++; $display("FAIL ori_alu_op: got %b want 10", bus0.alu_op); end
    n_chk++; if (bus0.alu_funct !== 6'b111111) begin n_fail++; $display("FAIL ori_alu_funct: got %b want 111111", bus0.alu_funct); end
    n_chk++; if (bus0.zero_ext !== 1'b1) begin n_fail++; $display("FAIL ori_zero_ext: got %b want 1", bus0.zero_ext); end
    n_chk++; if (bus0.alu_src_a !== 1'b1 || bus0.alu_src_b !== 2'b10) begin n_fail++;
      $display("FAIL ori_src: got %b/%b want 1/10", bus0.alu_src_a, bus0.alu_src_b); end
    step();
    n_chk++; if (bus0.state !== 4'd9 || bus0.reg_dst !== 1'b0 || bus0.reg_wr !== 1'b1 || bus0.mem_to_reg !== 1'b0) begin n_fail++;
      $display("FAIL ori_wb: got state %0d dst %b wr %b m2r %b want 9/0/1/0", bus0.state, bus0.reg_dst, bus0.reg_wr, bus0.mem_to_reg); end
    step();
    n_chk++; if (bus0.state !== 4'd0) begin n_fail++; $display("FAIL ori_return: got %0d want 0", bus0.state); end
  endtask

  task automatic test_rtype();
    bus0.instr_opcode = OP_RTYPE; bus0.instr_funct = 6'b100000;
    reset0(); step(); step();
    n_chk++; if (bus0.state !== 4'd6 || bus0.alu_op !== 2'b10 || bus0.alu_src_b !== 2'b00) begin n_fail++;
      $display("FAIL rtype_ex: got state %0d op %b src_b %b want 6/10/00", bus0.state, bus0.alu_op, bus0.alu_src_b); end
    n_chk++; if (bus0.alu_funct !== 6'b100000 || bus0.zero_ext !== 1'b0) begin n_fail++;
      $display("FAIL rtype_funct: got %b zext %b want 100000/0", bus0.alu_funct, bus0.zero_ext); end
    step();
    n_chk++; if (bus0.state !== 4'd7 || bus0.reg_dst !== 1'b1 || bus0.reg_wr !== 1'b1) begin n_fail++;
      $display("FAIL rtype_wb: got state %0d dst %b wr %b want 7/1/1", bus0.state, bus0.reg_dst, bus0.reg_wr); end
  endtask

  task automatic test_branch();
    bus0.instr_opcode = OP_BEQ; bus0.alu_zero = 1'b1;
    reset0(); step(); step();
    n_chk++; if (bus0.state !== 4'd10 || bus0.alu_op !== 2'b01) begin n_fail++;
      $display("FAIL beq_state: got %0d op %b want 10/01", bus0.state, bus0.alu_op); end
    n_chk++; if (bus0.pc_en !== 1'b1 || bus0.pc_src !== 2'b01) begin n_fail++;
      $display("FAIL beq_taken: got pc_en %b pc_src %b want 1/01", bus0.pc_en, bus0.pc_src); end
    bus0.alu_zero = 1'b0; #1;
    n_chk++; if (bus0.pc_en !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b want 0", bus0.pc_en); end
    step();
    n_chk++; if (bus0.state !== 4'd0) begin n_fail++; $display("FAIL beq_return: got %0d want 0", bus0.state); end
  endtask

  task automatic test_jump();
    bus0.instr_opcode = OP_J;
    reset0(); step(); step();
    n_chk++; if (bus0.state !== 4'd11 || bus0.pc_en !== 1'b1 || bus0.pc_src !== 2'b10) begin n_fail++;
      $display("FAIL jump: got state %0d pc_en %b pc_src %b want 11/1/10", bus0.state, bus0.pc_en, bus0.pc_src); end
    step();
    n_chk++; if (bus0.state !== 4'd0) begin n_fail++; $display("FAIL jump_return: got %0d want 0", bus0.state); end
  endtask

  task automatic test_illegal();
    bus0.instr_opcode = 6'b111111;
    reset0(); step();
    n_chk++; if (bus0.state !== 4'd1 || bus0.illegal_op !== 1'b1) begin n_fail++;
      $display("FAIL illegal_pulse: got state %0d illegal %b want 1/1", bus0.state, bus0.illegal_op); end
    n_chk++; if ({bus0.reg_wr, bus0.mem_wr, bus0.ir_wr, bus0.pc_en} !== 4'b0000) begin n_fail++;
      $display("FAIL illegal_strobes: got %b want 0000", {bus0.reg_wr, bus0.mem_wr, bus0.ir_wr, bus0.pc_en}); end
    step();
    n_chk++; if (bus0.state !== 4'd0 || bus0.illegal_op !== 1'b0) begin n_fail++;
      $display("FAIL illegal_return: got state %0d illegal %b want 0/0", bus0.state, bus0.illegal_op); end
    bus0.instr_opcode = OP_BNE; bus0.alu_zero = 1'b0;
    reset0(); step();
`ifdef MIPS_CTRL_BNE_EN
    step();
    n_chk++; if (bus0.state !== 4'd10 || bus0.pc_en !== 1'b1) begin n_fail++;
      $display("FAIL bne_taken: got state %0d pc_en %b want 10/1", bus0.state, bus0.pc_en); end
`else
    n_chk++; if (bus0.illegal_op !== 1'b1) begin n_fail++; $display("FAIL bne_illegal: got %b want 1", bus0.illegal_op); end
    step();
    n_chk++; if (bus0.state !== 4'd0) begin n_fail++; $display("FAIL bne_return: got %0d want 0", bus0.state); end
`endif
  endtask

  task automatic test_wait_sw();
    int exp_st[7] = '{0, 0, 0, 1, 2, 5, 0};
    logic exp_ir[7] = '{0, 0, 1, 0, 0, 0, 0};
    logic exp_mw[7] = '{0, 0, 0, 0, 0, 1, 0};
    bus2.instr_opcode = OP_SW; bus2.instr_funct = 6'd0; bus2.alu_zero = 1'b0;
    rst2 = 1'b1; step(); rst2 = 1'b0; #1;
    for (int c = 0; c < 7; c++) begin
      n_chk++; if (bus2.state !== 4'(exp_st[c])) begin n_fail++; $display("FAIL wsw_state[%0d]: got %0d want %0d", c, bus2.state, exp_st[c]); end
      n_chk++; if (bus2.ir_wr !== exp_ir[c]) begin n_fail++; $display("FAIL wsw_ir_wr[%0d]: got %b want %b", c, bus2.ir_wr, exp_ir[c]); end
      n_chk++; if (bus2.mem_wr !== exp_mw[c]) begin n_fail++; $display("FAIL wsw_mem_wr[%0d]: got %b want %b", c, bus2.mem_wr, exp_mw[c]); end
      step();
    end
  endtask

  initial begin
    bus2.instr_opcode = OP_SW; bus2.instr_funct = 6'd0; bus2.alu_zero = 1'b0;
    test_reset();
    test_lw();
    test_ori();
    test_rtype();
    test_branch();
    test_jump();
    test_illegal();
    test_wait_sw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
